// File: rtl/dac_output_stage.sv
// DAC output stage: Q2.14 gain with round-and-saturate, one pipeline register,
// then a first-word-fall-through FIFO presenting an AXI-Stream master to the DAC.
// Overflow/clip counters and a sticky underrun flag feed the status path.
module dac_output_stage #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned GAIN_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] s_axis_i,
  input  logic signed [DATA_WIDTH-1:0] s_axis_q,
  input  logic                         s_axis_valid,
  input  logic signed [GAIN_WIDTH-1:0] gain,
  input  logic                         clear_stats,
  output logic        [DATA_WIDTH-1:0] m_axis_dac_i,
  output logic        [DATA_WIDTH-1:0] m_axis_dac_q,
  output logic                         m_axis_dac_valid,
  input  logic                         m_axis_dac_ready,
  output logic        [ADDR_WIDTH:0]   fifo_level,
  output logic        [15:0]           overflow_cnt,
  output logic        [15:0]           clip_cnt,
  output logic                         underrun
);

  // One spare bit so the rounding add can never wrap.
  localparam int unsigned PW       = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int unsigned FracBits = GAIN_WIDTH - 2;

  typedef logic signed [PW-1:0] wide_t;

  localparam wide_t SatMax    = wide_t'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam wide_t SatMin    = -SatMax - wide_t'(1);
  localparam wide_t RoundBias = wide_t'(64'sd1 <<< (FracBits - 1));

  localparam logic [ADDR_WIDTH:0] LevelFull = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [15:0]         CntMax    = 16'hFFFF;

  // Returns {clipped, saturated result}.
  function automatic logic [DATA_WIDTH:0] scale_sat(input logic signed [DATA_WIDTH-1:0] x,
                                                    input logic signed [GAIN_WIDTH-1:0] g);
    wide_t                 p;
    wide_t                 r;
    logic [DATA_WIDTH:0]   res;
    p = wide_t'(x) * wide_t'(g);
    r = (p + RoundBias) >>> FracBits;
    if (r > SatMax) begin
      res = {1'b1, SatMax[DATA_WIDTH-1:0]};
    end else if (r < SatMin) begin
      res = {1'b1, SatMin[DATA_WIDTH-1:0]};
    end else begin
      res = {1'b0, r[DATA_WIDTH-1:0]};
    end
    return res;
  endfunction

  logic [DATA_WIDTH:0]   scaled_i;
  logic [DATA_WIDTH:0]   scaled_q;
  logic                  clip_event;

  logic [DATA_WIDTH-1:0] pipe_i_q, pipe_q_q;
  logic                  pipe_valid_q;

  logic [DATA_WIDTH-1:0] mem_i_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_q_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;

  logic                  full, pop, push, drop;

  logic [15:0]           overflow_cnt_q, overflow_cnt_d;
  logic [15:0]           clip_cnt_q, clip_cnt_d;
  logic                  underrun_q, underrun_d;
  logic                  primed_q, primed_d;

  // Gain, rounding and saturation for the incoming sample.
  always_comb begin
    scaled_i   = scale_sat(s_axis_i, gain);
    scaled_q   = scale_sat(s_axis_q, gain);
    clip_event = s_axis_valid & (scaled_i[DATA_WIDTH] | scaled_q[DATA_WIDTH]);
  end

  // Pipeline register: data only advances on a valid strobe, valid follows the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_i_q     <= '0;
      pipe_q_q     <= '0;
      pipe_valid_q <= 1'b0;
    end else begin
      pipe_valid_q <= s_axis_valid;
      if (s_axis_valid) begin
        pipe_i_q <= scaled_i[DATA_WIDTH-1:0];
        pipe_q_q <= scaled_q[DATA_WIDTH-1:0];
      end
    end
  end

  // FIFO control: a pop in the same cycle frees the slot a full-FIFO write needs.
  always_comb begin
    full     = (level_q == LevelFull);
    pop      = m_axis_dac_valid & m_axis_dac_ready;
    push     = pipe_valid_q & (~full | pop);
    drop     = pipe_valid_q & full & ~pop;
    wr_ptr_d = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + (ADDR_WIDTH + 1)'(1);
    end else if (pop && !push) begin
      level_d = level_q - (ADDR_WIDTH + 1)'(1);
    end
  end

  // FIFO storage; contents need no reset because the head is gated by valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_i_q[wr_ptr_q] <= pipe_i_q;
      mem_q_q[wr_ptr_q] <= pipe_q_q;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Statistics next state; clear_stats overrides any same-cycle event.
  always_comb begin
    overflow_cnt_d = overflow_cnt_q;
    clip_cnt_d     = clip_cnt_q;
    underrun_d     = underrun_q;
    primed_d       = primed_q;
    if (drop && overflow_cnt_q != CntMax) begin
      overflow_cnt_d = overflow_cnt_q + 16'd1;
    end
    if (clip_event && clip_cnt_q != CntMax) begin
      clip_cnt_d = clip_cnt_q + 16'd1;
    end
    if (primed_q && m_axis_dac_ready && !m_axis_dac_valid) begin
      underrun_d = 1'b1;
    end
    if (push) begin
      primed_d = 1'b1;
    end
    if (clear_stats) begin
      overflow_cnt_d = '0;
      clip_cnt_d     = '0;
      underrun_d     = 1'b0;
      primed_d       = 1'b0;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_cnt_q <= '0;
      clip_cnt_q     <= '0;
      underrun_q     <= 1'b0;
      primed_q       <= 1'b0;
    end else begin
      overflow_cnt_q <= overflow_cnt_d;
      clip_cnt_q     <= clip_cnt_d;
      underrun_q     <= underrun_d;
      primed_q       <= primed_d;
    end
  end

  // Output mapping; data forced to zero while empty so reset shows zeros.
  always_comb begin
    m_axis_dac_valid = (level_q != '0);
    m_axis_dac_i     = m_axis_dac_valid ? mem_i_q[rd_ptr_q] : '0;
    m_axis_dac_q     = m_axis_dac_valid ? mem_q_q[rd_ptr_q] : '0;
    fifo_level       = level_q;
    overflow_cnt     = overflow_cnt_q;
    clip_cnt         = clip_cnt_q;
    underrun         = underrun_q;
  end

endmodule

// File: tb/tb_dac_output_stage.sv
// Self-checking bench for dac_output_stage: directed scenarios plus random traffic,
// checked through a scoreboard queue filled by a transaction-level reference model.
module tb_dac_output_stage;

  localparam int Depth = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_axis_i, s_axis_q, gain;
  logic        s_axis_valid, clear_stats, m_axis_dac_ready;
  logic [15:0] m_axis_dac_i, m_axis_dac_q;
  logic        m_axis_dac_valid;
  logic [4:0]  fifo_level;
  logic [15:0] overflow_cnt, clip_cnt;
  logic        underrun;

  dac_output_stage dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_i         (s_axis_i),
    .s_axis_q         (s_axis_q),
    .s_axis_valid     (s_axis_valid),
    .gain             (gain),
    .clear_stats      (clear_stats),
    .m_axis_dac_i     (m_axis_dac_i),
    .m_axis_dac_q     (m_axis_dac_q),
    .m_axis_dac_valid (m_axis_dac_valid),
    .m_axis_dac_ready (m_axis_dac_ready),
    .fifo_level       (fifo_level),
    .overflow_cnt     (overflow_cnt),
    .clip_cnt         (clip_cnt),
    .underrun         (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state (transaction level: an occupancy count and a queue).
  logic [31:0] sb_q[$];
  bit          m_pipe_v;
  logic [31:0] m_pipe;
  int          m_cnt, m_ovf, m_clip;
  bit          m_primed, m_under, m_was_rst, started;

  // Gain with round-half-up done by floor division, then clamp to 16-bit range.
  function automatic void ref_scale(input int x, input int g, output logic [15:0] r,
                                    output bit c);
    longint p, t, f;
    p = longint'(x) * longint'(g);
    t = p + 64'sd8192;
    if (t >= 0) f = t / 16384;
    else        f = -((-t + 16383) / 16384);
    c = 1'b1;
    if (f > 32767)       r = 16'h7FFF;
    else if (f < -32768) r = 16'h8000;
    else begin
      r = 16'(f);
      c = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at every rising edge, using the inputs the DUT sees.
  always @(posedge clk) begin
    bit          pop, push, ci, cq;
    logic [15:0] ri, rq;
    if (rst) begin
      sb_q.delete();
      m_pipe_v  = 1'b0;
      m_cnt     = 0;
      m_ovf     = 0;
      m_clip    = 0;
      m_primed  = 1'b0;
      m_under   = 1'b0;
      m_was_rst = 1'b1;
      started   = 1'b1;
    end else begin
      m_was_rst = 1'b0;
      pop  = m_axis_dac_ready && (m_cnt > 0);
      push = 1'b0;
      if (m_primed && m_axis_dac_ready && m_cnt == 0) m_under = 1'b1;
      if (m_pipe_v) begin
        if (m_cnt < Depth || pop) begin
          sb_q.push_back(m_pipe);
          m_cnt++;
          push = 1'b1;
        end else if (m_ovf < 65535) begin
          m_ovf++;
        end
      end
      if (pop) m_cnt--;
      if (push) m_primed = 1'b1;
      if (s_axis_valid) begin
        ref_scale($signed(s_axis_i), $signed(gain), ri, ci);
        ref_scale($signed(s_axis_q), $signed(gain), rq, cq);
        m_pipe = {ri, rq};
        if ((ci || cq) && m_clip < 65535) m_clip++;
      end
      m_pipe_v = s_axis_valid;
      if (clear_stats) begin
        m_ovf    = 0;
        m_clip   = 0;
        m_under  = 1'b0;
        m_primed = 1'b0;
      end
    end
  end

  // Monitor on the falling edge: status against the model, head data against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (started) begin
      chk("valid", 64'(m_axis_dac_valid), 64'(m_cnt != 0));
      chk("fifo_level", 64'(fifo_level), 64'(m_cnt));
      chk("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
      chk("clip_cnt", 64'(clip_cnt), 64'(m_clip));
      chk("underrun", 64'(underrun), 64'(m_under));
      if (m_was_rst) chk("reset_data", 64'({m_axis_dac_i, m_axis_dac_q}), 64'(0));
      if (m_axis_dac_valid === 1'b1 && m_axis_dac_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL data: got %h_%h expected nothing (scoreboard empty) at %0t",
                   m_axis_dac_i, m_axis_dac_q, $time);
        end else begin
          exp = sb_q.pop_front();
          chk("data_iq", 64'({m_axis_dac_i, m_axis_dac_q}), 64'(exp));
        end
      end
    end
  end

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic cyc(input bit v, input logic [15:0] i, input logic [15:0] q,
                     input logic [15:0] g, input bit rdy, input bit clr, input bit rs);
    s_axis_valid     = v;
    s_axis_i         = i;
    s_axis_q         = q;
    gain             = g;
    m_axis_dac_ready = rdy;
    clear_stats      = clr;
    rst              = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, 16'h0, 16'h0, 16'd16384, rdy, 1'b0, 1'b0);
  endtask

  task automatic smp(input int k, input bit rdy);
    logic [15:0] v;
    v = 16'(k * 257 + 1);
    cyc(1'b1, v, ~v, 16'd16384, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] g;
    repeat (3) cyc(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

    // Unity gain passthrough.
    cyc(1'b1, 16'h1234, 16'hEDCC, 16'd16384, 1'b1, 1'b0, 1'b0);
    repeat (4) idle(1'b1);

    // Saturation both ways, then rounding.
    cyc(1'b1, 16'h7000, 16'h0000, 16'd32767, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h9000, 16'h0000, 16'd32767, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0003, 16'hFFFD, 16'd8192, 1'b1, 1'b0, 1'b0);
    repeat (4) idle(1'b1);

    // Overflow: 20 samples into a stalled DAC, then drain.
    for (int k = 0; k < 20; k++) smp(k, 1'b0);
    idle(1'b0);
    repeat (20) idle(1'b1);

    // Full FIFO with a continuous stream and the DAC accepting every cycle.
    for (int k = 0; k < 17; k++) smp(k + 40, 1'b0);
    for (int k = 0; k < 30; k++) smp(k + 60, 1'b1);
    repeat (20) idle(1'b1);

    // Underrun after priming with a single sample.
    cyc(1'b0, 16'h0, 16'h0, 16'd16384, 1'b1, 1'b1, 1'b0);
    smp(100, 1'b1);
    repeat (5) idle(1'b1);

    // clear_stats coincident with an overflow.
    for (int k = 0; k < 18; k++) smp(k + 120, 1'b0);
    cyc(1'b0, 16'h0, 16'h0, 16'd16384, 1'b0, 1'b1, 1'b0);
    repeat (20) idle(1'b1);

    // Mid-stream reset with 8 samples buffered; the reset-cycle sample is ignored.
    for (int k = 0; k < 8; k++) smp(k + 150, 1'b0);
    idle(1'b0);
    cyc(1'b1, 16'h5555, 16'hAAAA, 16'd16384, 1'b0, 1'b0, 1'b1);
    smp(170, 1'b1);
    repeat (4) idle(1'b1);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0:       g = 16'($urandom);
        1:       g = 16'd16384;
        2:       g = 16'd32767;
        default: g = 16'($urandom_range(8000, 24000));
      endcase
      cyc(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), g,
          ((n / 64) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 99) == 0), ($urandom_range(0, 499) == 0));
    end
    repeat (30) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
